id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and saturating bubble/flush counters.
// Latency 1 cycle; mem_stall freezes the register, and stall_D holds fetch/decode during a stall or load-use bubble.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D_valid,
    input  logic [6:0]       D_opcode,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic [4:0]       D_rd,
    input  logic             D_reg_write_enable,
    input  logic [XLEN-1:0]  D_rd1,
    input  logic [XLEN-1:0]  D_rd2,
    input  logic [XLEN-1:0]  D_imm,
    input  logic [XLEN-1:0]  D_pc,
    input  logic [2:0]       D_funct3,
    input  logic             D_funct7b5,
    input  logic             mem_stall,
    input  logic             flush_E,
    output logic             E_valid,
    output logic [6:0]       E_opcode,
    output logic [4:0]       ex_reg_a,
    output logic [4:0]       ex_reg_b,
    output logic [4:0]       E_rd,
    output logic             E_reg_write_enable,
    output logic [XLEN-1:0]  E_rd1,
    output logic [XLEN-1:0]  E_rd2,
    output logic [XLEN-1:0]  E_imm,
    output logic [XLEN-1:0]  E_pc,
    output logic [2:0]       E_funct3,
    output logic             E_funct7b5,
    output logic             stall_D,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [2:0]      funct3;
        logic            funct7b5;
    } ex_t;

    ex_t              r_e;
    ex_t              w_e_nxt;
    ex_t              w_d;
    ex_t              w_bubble;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_bubble_cnt_nxt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_load_use;

    // A bubble is a canonical NOP (addi x0,x0,0) that writes nothing.
    always_comb begin
        w_bubble        = '0;
        w_bubble.opcode = OP_OPIMM;
    end

    always_comb begin
        w_d          = '0;
        w_d.valid    = D_valid;
        w_d.opcode   = D_opcode;
        w_d.rs1      = D_rs1;
        w_d.rs2      = D_rs2;
        w_d.rd       = D_rd;
        w_d.we       = D_reg_write_enable;
        w_d.rd1      = D_rd1;
        w_d.rd2      = D_rd2;
        w_d.imm      = D_imm;
        w_d.pc       = D_pc;
        w_d.funct3   = D_funct3;
        w_d.funct7b5 = D_funct7b5;
    end

    assign w_rs1_used = !((D_opcode == OP_LUI) || (D_opcode == OP_AUIPC) || (D_opcode == OP_JAL));
    assign w_rs2_used = (D_opcode == OP_OP) || (D_opcode == OP_STORE) || (D_opcode == OP_BRANCH);

    assign w_load_use = r_e.valid && (r_e.opcode == OP_LOAD) && (r_e.rd != 5'd0) && D_valid &&
                        ((w_rs1_used && (D_rs1 == r_e.rd)) || (w_rs2_used && (D_rs2 == r_e.rd)));

    // A flush kills the decode instruction anyway, so a coincident load-use never stalls.
    assign stall_D = mem_stall | (w_load_use & ~flush_E);

    always_comb begin
        w_e_nxt          = r_e;
        w_bubble_cnt_nxt = r_bubble_cnt;
        w_flush_cnt_nxt  = r_flush_cnt;
        if (mem_stall) begin
            w_e_nxt = r_e;
        end else if (flush_E) begin
            w_e_nxt = w_bubble;
            if (r_flush_cnt != '1) begin
                w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
            end
        end else if (w_load_use) begin
            w_e_nxt = w_bubble;
            if (r_bubble_cnt != '1) begin
                w_bubble_cnt_nxt = r_bubble_cnt + CNT_W'(1);
            end
        end else if (D_valid) begin
            w_e_nxt = w_d;
        end else begin
            w_e_nxt = w_bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e          <= w_bubble;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_e          <= w_e_nxt;
            r_bubble_cnt <= w_bubble_cnt_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
        end
    end

    assign E_valid            = r_e.valid;
    assign E_opcode           = r_e.opcode;
    assign ex_reg_a           = r_e.rs1;
    assign ex_reg_b           = r_e.rs2;
    assign E_rd               = r_e.rd;
    assign E_reg_write_enable = r_e.we;
    assign E_rd1              = r_e.rd1;
    assign E_rd2              = r_e.rd2;
    assign E_imm              = r_e.imm;
    assign E_pc               = r_e.pc;
    assign E_funct3           = r_e.funct3;
    assign E_funct7b5         = r_e.funct7b5;
    assign bubble_count       = r_bubble_cnt;
    assign flush_count        = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed decode vectors push expected stall_D and
// next-cycle execute state; a monitor compares them as the DUT presents each cycle.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] JAL   = 7'b1101111;

    logic             clk = 1'b0;
    logic             rst;
    logic             D_valid;
    logic [6:0]       D_opcode;
    logic [4:0]       D_rs1, D_rs2, D_rd;
    logic             D_reg_write_enable;
    logic [XLEN-1:0]  D_rd1, D_rd2, D_imm, D_pc;
    logic [2:0]       D_funct3;
    logic             D_funct7b5;
    logic             mem_stall, flush_E;
    logic             E_valid;
    logic [6:0]       E_opcode;
    logic [4:0]       ex_reg_a, ex_reg_b, E_rd;
    logic             E_reg_write_enable;
    logic [XLEN-1:0]  E_rd1, E_rd2, E_imm, E_pc;
    logic [2:0]       E_funct3;
    logic             E_funct7b5;
    logic             stall_D;
    logic [CNT_W-1:0] bubble_count, flush_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .D_valid(D_valid), .D_opcode(D_opcode), .D_rs1(D_rs1), .D_rs2(D_rs2), .D_rd(D_rd),
        .D_reg_write_enable(D_reg_write_enable),
        .D_rd1(D_rd1), .D_rd2(D_rd2), .D_imm(D_imm), .D_pc(D_pc),
        .D_funct3(D_funct3), .D_funct7b5(D_funct7b5),
        .mem_stall(mem_stall), .flush_E(flush_E),
        .E_valid(E_valid), .E_opcode(E_opcode), .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b), .E_rd(E_rd),
        .E_reg_write_enable(E_reg_write_enable),
        .E_rd1(E_rd1), .E_rd2(E_rd2), .E_imm(E_imm), .E_pc(E_pc),
        .E_funct3(E_funct3), .E_funct7b5(E_funct7b5),
        .stall_D(stall_D), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    typedef struct {
        logic [6:0] op;
        logic [4:0] s1, s2, rd;
        logic       we;
        int         tag;
    } ins_t;

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [4:0] a, b, rd;
        logic       we;
        int         tag;
    } st_t;

    typedef struct {
        logic stall;
        logic full;
        st_t  e;
        int   bc;
        int   fc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic ins_t I(logic [6:0] op, logic [4:0] s1, logic [4:0] s2, logic [4:0] rd, logic we, int tag);
        ins_t r;
        r.op = op; r.s1 = s1; r.s2 = s2; r.rd = rd; r.we = we; r.tag = tag;
        return r;
    endfunction

    // Expected execute state once instruction i has been loaded.
    function automatic st_t S(ins_t i);
        st_t r;
        r.v = 1'b1; r.op = i.op; r.a = i.s1; r.b = i.s2; r.rd = i.rd; r.we = i.we; r.tag = i.tag;
        return r;
    endfunction

    function automatic st_t bub();
        st_t r;
        r.v = 1'b0; r.op = OPIMM; r.a = 5'd0; r.b = 5'd0; r.rd = 5'd0; r.we = 1'b0; r.tag = 0;
        return r;
    endfunction

    // Data payload is a tag-derived pattern so every loaded field is distinguishable; tag 0 is a bubble.
    function automatic logic [31:0] pat(int tag, int base);
        return (tag == 0) ? 32'h0 : 32'(base + tag);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic r, input logic ms, input logic fl, input logic dv, input ins_t d,
                       input logic xs, input st_t xe, input int bc, input int fc, input logic full = 1'b1);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; mem_stall = ms; flush_E = fl; D_valid = dv;
        D_opcode = d.op; D_rs1 = d.s1; D_rs2 = d.s2; D_rd = d.rd; D_reg_write_enable = d.we;
        D_rd1 = pat(d.tag, 32'h1000); D_rd2 = pat(d.tag, 32'h2000);
        D_imm = pat(d.tag, 32'h3000); D_pc = pat(d.tag * 4, 32'h4000);
        D_funct3 = d.tag[2:0]; D_funct7b5 = d.tag[3];
        x.stall = xs; x.full = full; x.e = xe; x.bc = bc; x.fc = fc;
        q.push_back(x);
    endtask

    // Monitor: stall_D is checked mid-cycle for the vector just driven, the register state after the next edge.
    initial begin
        logic armed;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                chk("stall_D", stall_D, q[0].stall);
                armed = 1'b1;
            end
            @(posedge clk);
            #3;
            if (armed) begin
                exp_t x;
                x = q.pop_front();
                armed = 1'b0;
                chk("E_valid", E_valid, x.e.v);
                chk("E_reg_write_enable", E_reg_write_enable, x.e.we);
                chk("bubble_count", bubble_count, x.bc);
                chk("flush_count", flush_count, x.fc);
                if (x.full) begin
                    chk("E_opcode", E_opcode, x.e.op);
                    chk("ex_reg_a", ex_reg_a, x.e.a);
                    chk("ex_reg_b", ex_reg_b, x.e.b);
                    chk("E_rd", E_rd, x.e.rd);
                    chk("E_rd1", E_rd1, pat(x.e.tag, 32'h1000));
                    chk("E_rd2", E_rd2, pat(x.e.tag, 32'h2000));
                    chk("E_imm", E_imm, pat(x.e.tag, 32'h3000));
                    chk("E_pc", E_pc, pat(x.e.tag * 4, 32'h4000));
                    chk("E_funct3", E_funct3, x.e.tag[2:0]);
                    chk("E_funct7b5", E_funct7b5, x.e.tag[3]);
                end
            end
        end
    end

    initial begin
        ins_t i;
        ins_t ld;
        int   bcv;
        rst = 1'b1; mem_stall = 1'b0; flush_E = 1'b0; D_valid = 1'b0;
        D_opcode = 7'd0; D_rs1 = 5'd0; D_rs2 = 5'd0; D_rd = 5'd0; D_reg_write_enable = 1'b0;
        D_rd1 = '0; D_rd2 = '0; D_imm = '0; D_pc = '0; D_funct3 = 3'd0; D_funct7b5 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset wins over hold; stall_D still follows mem_stall during reset.
        drv(1, 1, 0, 1, I(OP, 5, 7, 6, 1, 2), 1, bub(), 0, 0);

        // lw x5 then add x6,x5,x7: one bubble, then the add enters with ex_reg_a=5.
        i = I(LOAD, 1, 0, 5, 1, 1);   drv(0, 0, 0, 1, i, 0, S(i), 0, 0);
        i = I(OP, 5, 7, 6, 1, 2);     drv(0, 0, 0, 1, i, 1, bub(), 1, 0);
                                      drv(0, 0, 0, 1, i, 0, S(i), 1, 0);

        // Load to x0 never creates a hazard.
        i = I(LOAD, 2, 0, 0, 1, 3);   drv(0, 0, 0, 1, i, 0, S(i), 1, 0);
        i = I(OP, 0, 0, 8, 1, 4);     drv(0, 0, 0, 1, i, 0, S(i), 1, 0);

        // lui ignores its rs fields; sw uses rs2 and stalls.
        i = I(LOAD, 1, 0, 5, 1, 5);   drv(0, 0, 0, 1, i, 0, S(i), 1, 0);
        i = I(LUI, 5, 5, 9, 1, 6);    drv(0, 0, 0, 1, i, 0, S(i), 1, 0);
        i = I(LOAD, 1, 0, 5, 1, 7);   drv(0, 0, 0, 1, i, 0, S(i), 1, 0);
        i = I(STORE, 3, 5, 0, 0, 8);  drv(0, 0, 0, 1, i, 1, bub(), 2, 0);
                                      drv(0, 0, 0, 1, i, 0, S(i), 2, 0);

        // addi does not read rs2; jal does not read rs1.
        i = I(LOAD, 1, 0, 5, 1, 9);   drv(0, 0, 0, 1, i, 0, S(i), 2, 0);
        i = I(OPIMM, 3, 5, 10, 1, 10); drv(0, 0, 0, 1, i, 0, S(i), 2, 0);
        i = I(LOAD, 1, 0, 5, 1, 11);  drv(0, 0, 0, 1, i, 0, S(i), 2, 0);
        i = I(JAL, 5, 0, 1, 1, 12);   drv(0, 0, 0, 1, i, 0, S(i), 2, 0);

        // Flush coincident with load-use: no stall, flush bubble counted only.
        i = I(LOAD, 1, 0, 5, 1, 13);  drv(0, 0, 0, 1, i, 0, S(i), 2, 0);
        i = I(OP, 5, 7, 6, 1, 14);    drv(0, 0, 1, 1, i, 0, bub(), 2, 1);

        // mem_stall with flush and load-use pending: frozen for 3 cycles, then the flush applies.
        ld = I(LOAD, 1, 0, 5, 1, 15); drv(0, 0, 0, 1, ld, 0, S(ld), 2, 1);
        i = I(OP, 5, 7, 6, 1, 16);
        drv(0, 1, 1, 1, i, 1, S(ld), 2, 1);
        drv(0, 1, 1, 1, i, 1, S(ld), 2, 1);
        drv(0, 1, 1, 1, i, 1, S(ld), 2, 1);
        drv(0, 0, 1, 1, i, 0, bub(), 2, 2);

        // Invalid decode slot loads as a non-writing bubble and cannot raise load-use.
        i = I(LOAD, 1, 0, 5, 1, 17);  drv(0, 0, 0, 1, i, 0, S(i), 2, 2);
        drv(0, 0, 0, 0, I(OP, 5, 7, 6, 1, 18), 0, bub(), 2, 2, 1'b0);

        // Drive bubble_count into saturation and past it.
        bcv = 2;
        for (int k = 1; k <= 260; k++) begin
            i = I(LOAD, 1, 0, 5, 1, 20);
            drv(0, 0, 0, 1, i, 0, S(i), bcv, 2);
            bcv = (bcv < 255) ? bcv + 1 : 255;
            drv(0, 0, 0, 1, I(OP, 5, 7, 6, 1, 21), 1, bub(), bcv, 2);
        end
        i = I(LOAD, 1, 0, 5, 1, 22);  drv(0, 0, 0, 1, i, 0, S(i), 255, 2);

        // Reset during hold + flush + load-use clears everything; the add then loads without a stall.
        i = I(OP, 5, 7, 6, 1, 23);
        drv(1, 1, 1, 1, i, 1, bub(), 0, 0);
        drv(0, 0, 0, 1, i, 0, S(i), 0, 0);

        for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
